// File: rtl/rv523_regfile_pkg.sv
// Shared constants and helpers for the RV523 integer register file.
package rv523_regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;

  // Values of the RDREG parameter: combinational or registered read data.
  localparam int RDREG_COMB = 0;
  localparam int RDREG_FLOP = 1;

  // Address width needed to index a register file of the given depth.
  function automatic int aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rv523_dffre.sv
// W-bit D flip-flop with synchronous active-low reset and load enable.
module rv523_dffre #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset has priority over a load so a write in a reset cycle is lost.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rv523_regfile.sv
// RV523 integer register file: one write port, NREAD read ports, x0 tied
// to zero, optional write-to-read bypass and optional registered read data.
module rv523_regfile
  import rv523_regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  parameter int RDREG  = RDREG_COMB
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [aw(DEPTH)-1:0]        waddr,
  input  logic [XLEN-1:0]             wdata,
  input  logic [NREAD*aw(DEPTH)-1:0]  raddr,
  output logic [NREAD*XLEN-1:0]       rdata
);

  localparam int AW = aw(DEPTH);

  // Architectural state; entry 0 is a constant, not storage.
  logic [DEPTH-1:0][XLEN-1:0] regs;

  assign regs[0] = '0;

  // NOTE: every register is a resettable flop (not an SRAM), so one reset
  // edge leaves the whole file at zero with no partial state.
  for (genvar r = 1; r < DEPTH; r++) begin : g_reg
    logic wr_en;

    assign wr_en = we && (waddr == AW'(r));

    rv523_dffre #(.W(XLEN)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wr_en),
      .d     (wdata),
      .q     (regs[r])
    );
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd_val;

    assign ra = raddr[p*AW +: AW];

    // Per-port read value: x0 is zero, a matching write forwards when the
    // bypass is enabled and the file is out of reset, else the stored value.
    always_comb begin
      // NOTE: default first so every path assigns rd_val and no latch forms.
      rd_val = regs[ra];
      if (ra == '0) begin
        rd_val = '0;
      end else if ((BYPASS != 0) && we && rst_n && (waddr == ra)) begin
        rd_val = wdata;
      end
    end

    if (RDREG == RDREG_FLOP) begin : g_flop
      rv523_dffre #(.W(XLEN)) u_rd (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .d     (rd_val),
        .q     (rdata[p*XLEN +: XLEN])
      );
    end else begin : g_comb
      assign rdata[p*XLEN +: XLEN] = rd_val;
    end
  end

endmodule

// File: tb/tb_rv523_regfile.sv
// Self-checking bench for rv523_regfile. Two 32x32 two-port instances share
// directed stimulus (bypass+combinational read, and no-bypass+registered
// read); a small 8-bit/4-entry/3-port instance gets a random run with resets.
module tb_rv523_regfile;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata_a;
  logic [63:0] rdata_b;

  logic        rst_n_c;
  logic        we_c;
  logic [1:0]  waddr_c;
  logic [7:0]  wdata_c;
  logic [5:0]  raddr_c;
  logic [23:0] rdata_c;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic [31:0] mdl   [32];
  logic [7:0]  mdl_c [4];
  logic [63:0] q_a [$];
  logic [63:0] q_b [$];
  logic [23:0] q_c [$];

  rv523_regfile #(.XLEN(32), .DEPTH(32), .NREAD(2), .BYPASS(1), .RDREG(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a)
  );

  rv523_regfile #(.XLEN(32), .DEPTH(32), .NREAD(2), .BYPASS(0), .RDREG(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b)
  );

  rv523_regfile #(.XLEN(8), .DEPTH(4), .NREAD(3), .BYPASS(1), .RDREG(1)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .we(we_c), .waddr(waddr_c), .wdata(wdata_c),
    .raddr(raddr_c), .rdata(rdata_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  // Expected read value of the 32-bit files for the inputs currently driven.
  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (ra == 5'd0) return 32'd0;
    if (byp && rst_n && we && (waddr == ra)) return wdata;
    return mdl[ra];
  endfunction

  function automatic logic [7:0] exp_rd_c(input logic [1:0] ra);
    if (ra == 2'd0) return 8'd0;
    if (rst_n_c && we_c && (waddr_c == ra)) return wdata_c;
    return mdl_c[ra];
  endfunction

  // One clock of stimulus to the 32-bit files: drive, queue expectations,
  // compare at the falling edge, then advance the model at the rising edge.
  task automatic cyc(input logic r, input logic w, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] ra0,
                     input logic [4:0] ra1);
    logic [63:0] e;
    rst_n = r; we = w; waddr = wa; wdata = wd; raddr = {ra1, ra0};
    q_a.push_back({exp_rd(ra1, 1'b1), exp_rd(ra0, 1'b1)});
    // A reset edge clears the read-data flops regardless of the read value.
    q_b.push_back(r ? {exp_rd(ra1, 1'b0), exp_rd(ra0, 1'b0)} : 64'd0);
    @(negedge clk);
    e = q_a.pop_front();
    check($sformatf("byp_p0@%0d", cyc_n), rdata_a[31:0],  e[31:0]);
    check($sformatf("byp_p1@%0d", cyc_n), rdata_a[63:32], e[63:32]);
    e = q_b.pop_front();
    check($sformatf("reg_p0@%0d", cyc_n), rdata_b[31:0],  e[31:0]);
    check($sformatf("reg_p1@%0d", cyc_n), rdata_b[63:32], e[63:32]);
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    end else if (w && wa != 5'd0) begin
      mdl[wa] = wd;
    end
    cyc_n++;
    #1;
  endtask

  task automatic cyc_c(input logic r, input logic w, input logic [1:0] wa,
                       input logic [7:0] wd, input logic [5:0] ras);
    logic [23:0] e;
    rst_n_c = r; we_c = w; waddr_c = wa; wdata_c = wd; raddr_c = ras;
    q_c.push_back(r ? {exp_rd_c(ras[5:4]), exp_rd_c(ras[3:2]), exp_rd_c(ras[1:0])}
                    : 24'd0);
    @(negedge clk);
    e = q_c.pop_front();
    for (int p = 0; p < 3; p++) begin
      check($sformatf("sweep_p%0d@%0d", p, cyc_n),
            {24'd0, rdata_c[p*8 +: 8]}, {24'd0, e[p*8 +: 8]});
    end
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 4; i++) mdl_c[i] = 8'd0;
    end else if (w && wa != 2'd0) begin
      mdl_c[wa] = wd;
    end
    cyc_n++;
    #1;
  endtask

  initial begin
    logic [5:0] ras;
    logic       r;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    rst_n_c = 1'b0; we_c = 1'b0; waddr_c = '0; wdata_c = '0; raddr_c = '0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    for (int i = 0; i < 4; i++) mdl_c[i] = 8'd0;
    // The first reset edge below leaves every registered read port at zero.
    q_b.push_back(64'd0);
    q_c.push_back(24'd0);
    @(posedge clk);
    #1;

    // Reset held, then released; reads of x0, x1, x31 are all zero.
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd31);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd1);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd31, 5'd0);

    // Writes to x0 are discarded and never forwarded.
    cyc(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Basic write/read, including a read of x31 while it is written.
    cyc(1'b1, 1'b1, 5'd5,  32'h12345678, 5'd0, 5'd0);
    cyc(1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd5, 5'd31);
    cyc(1'b1, 1'b0, 5'd0,  32'd0,        5'd5, 5'd31);

    // Bypass: x7 holds 1, then both ports read x7 while it is rewritten.
    cyc(1'b1, 1'b1, 5'd7, 32'h00000001, 5'd0, 5'd0);
    cyc(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
    cyc(1'b1, 1'b0, 5'd0, 32'd0,        5'd7, 5'd7);

    // Reset beats a simultaneous write, and the bypass stays quiet.
    cyc(1'b1, 1'b1, 5'd3, 32'h00000055, 5'd0, 5'd0);
    cyc(1'b0, 1'b1, 5'd3, 32'h000000AA, 5'd3, 5'd3);
    cyc(1'b1, 1'b0, 5'd0, 32'd0,        5'd3, 5'd5);

    // Back-to-back writes to x9 with x9 read every cycle.
    cyc(1'b1, 1'b1, 5'd9, 32'd1, 5'd9, 5'd9);
    cyc(1'b1, 1'b1, 5'd9, 32'd2, 5'd9, 5'd9);
    cyc(1'b1, 1'b1, 5'd9, 32'd3, 5'd9, 5'd9);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    check("x9_final", rdata_a[31:0], 32'd3);

    // Random run on the narrow three-port file with occasional resets.
    for (int i = 0; i < 1000; i++) begin
      r   = ($urandom_range(0, 39) != 0) && (i != 500);
      ras = 6'($urandom);
      cyc_c(r, ($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), ras);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
